// File: rtl/arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrated output register.
// Select width and last-grant reset value.
package arb_mux_pkg;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Last grant resets to the top channel so channel 0 wins first.
  function automatic int lg_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts after i_last and wraps; first request wins.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = sel_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int   w_c;
  logic w_hit;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    w_c   = 0;
    for (int k = 1; k <= N; k++) begin
      w_c = (int'(i_last) + k) % N;
      if (i_en && !w_hit && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_idx      = IW'(w_c);
        w_hit      = 1'b1;
      end
    end
  end

  assign o_any = w_hit;

endmodule

// File: rtl/arb_mux.sv
// Round-robin N:1 mux into a one-deep registered output stage.
// Define ARB_MUX_FORCE_EN to add force_en/force_sel override ports.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int BUS_WIDTH = 4,
  parameter int CHANNELS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef ARB_MUX_FORCE_EN
  input  logic                          force_en,
  input  logic [sel_w(CHANNELS)-1:0]    force_sel,
`endif
  input  logic [CHANNELS*BUS_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  output logic [BUS_WIDTH-1:0]          q,
  output logic                          q_valid,
  input  logic                          q_ready,
  output logic [sel_w(CHANNELS)-1:0]    q_sel
);

  localparam int SW = sel_w(CHANNELS);
  localparam logic [SW-1:0] LG_RST = SW'(lg_rst(CHANNELS));

  logic [BUS_WIDTH-1:0] r_q;
  logic                 r_qv;
  logic [SW-1:0]        r_sel;
  logic [SW-1:0]        r_last;

  logic                 w_load;
  logic                 w_forced;
  logic [CHANNELS-1:0]  w_req;
  logic [CHANNELS-1:0]  w_gnt;
  logic [SW-1:0]        w_idx;
  logic                 w_any;

  assign w_load = !r_qv || q_ready;

`ifdef ARB_MUX_FORCE_EN
  assign w_forced = force_en;
  assign w_req    = force_en
                  ? (in_valid & (CHANNELS'(1) << force_sel))
                  : in_valid;
`else
  assign w_forced = 1'b0;
  assign w_req    = in_valid;
`endif

  // Gated by rst_n so no handshake is offered while held in reset.
  rr_arbiter #(
    .N  (CHANNELS),
    .IW (SW)
  ) u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .i_en   (w_load & rst_n),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign in_ready = w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_qv   <= 1'b0;
      r_sel  <= '0;
      r_last <= LG_RST;
    end else if (w_any) begin
      r_q   <= in_data[w_idx*BUS_WIDTH +: BUS_WIDTH];
      r_qv  <= 1'b1;
      r_sel <= w_idx;
      if (!w_forced) r_last <= w_idx;
    end else if (w_load) begin
      r_qv <= 1'b0;
    end
  end

  assign q       = r_q;
  assign q_valid = r_qv;
  assign q_sel   = r_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux (CHANNELS=4, BUS_WIDTH=4).
// Directed scenarios plus a randomized run against a queue-free model.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [3:0]  q;
  logic        q_valid;
  logic        q_ready = 1'b0;
  logic [1:0]  q_sel;
`ifdef ARB_MUX_FORCE_EN
  logic        force_en = 1'b0;
  logic [1:0]  force_sel = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arb_mux #(
    .BUS_WIDTH (4),
    .CHANNELS  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ARB_MUX_FORCE_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_sel     (q_sel)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0;
    q_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 4'hF;
    q_ready = 1'b1;
    #1;
    n_chk++;
    if (q !== 4'd0 || q_valid !== 1'b0 || q_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_out: got q=%h v=%b s=%0d want 0/0/0",
               q, q_valid, q_sel);
    end
    n_chk++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b want 0000", in_ready);
    end
    @(negedge clk);
    in_valid = '0;
    q_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] eq [5] = '{4'd1, 4'd7, 4'd3, 4'd5, 4'd1};
    logic [1:0] es [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    test_reset();
    in_data = 16'h5371;
    q_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 4'hF;
      #1;
      n_chk++;
      if (in_ready !== (4'b0001 << es[i])) begin
        n_fail++;
        $display("FAIL rr_rdy[%0d]: got %b want %b",
                 i, in_ready, 4'b0001 << es[i]);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (q !== eq[i] || q_sel !== es[i] || q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_q[%0d]: got q=%0d s=%0d v=%b want %0d/%0d/1",
                 i, q, q_sel, q_valid, eq[i], es[i]);
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0] es [3] = '{2'd1, 2'd3, 2'd1};
    test_reset();
    in_data = 16'h5371;
    q_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 4'b1010;
      #1;
      n_chk++;
      if (in_ready !== (4'b0001 << es[i])) begin
        n_fail++;
        $display("FAIL alt_rdy[%0d]: got %b want %b",
                 i, in_ready, 4'b0001 << es[i]);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (q_sel !== es[i] || q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL alt_sel[%0d]: got %0d v=%b want %0d",
                 i, q_sel, q_valid, es[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    in_data = 16'h5371;
    @(negedge clk);
    in_valid = 4'b0100;
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (q !== 4'd3 || q_sel !== 2'd2 || q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_load: got q=%0d s=%0d v=%b want 3/2/1",
               q, q_sel, q_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 4'hF;
      q_ready = 1'b0;
      #1;
      n_chk++;
      if (in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_rdy[%0d]: got %b want 0000", i, in_ready);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (q !== 4'd3 || q_valid !== 1'b1 || q_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got q=%0d v=%b s=%0d want 3/1/2",
                 i, q, q_valid, q_sel);
      end
    end
    @(negedge clk);
    q_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_next_rdy: got %b want 1000", in_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (q !== 4'd5 || q_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_next_q: got q=%0d s=%0d want 5/3", q, q_sel);
    end
  endtask

  task automatic test_idle();
    test_reset();
    in_data = 16'h5371;
    @(negedge clk);
    in_valid = 4'b1000;
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    n_chk++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_rdy: got %b want 0000", in_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (q_valid !== 1'b0 || q !== 4'd5 || q_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL idle_hold: got v=%b q=%0d s=%0d want 0/5/3",
               q_valid, q, q_sel);
    end
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL idle_wrap: got %b want 0001", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    test_reset();
    in_data = 16'h5371;
    q_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      in_valid = 4'hF;
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (q !== 4'd0 || q_valid !== 1'b0 || q_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL areset: got q=%0d v=%b s=%0d want 0/0/0",
               q, q_valid, q_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL areset_first: got %b want 0001", in_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (q !== 4'd1 || q_sel !== 2'd0 || q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_q: got q=%0d s=%0d v=%b want 1/0/1",
               q, q_sel, q_valid);
    end
  endtask

  task automatic test_random();
    int lg, win, es;
    bit eqv, load;
    logic [3:0] eq, er;
    test_reset();
    lg = 3;
    eqv = 0;
    eq = '0;
    es = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid = 4'($urandom_range(0, 15));
      q_ready = ($urandom % 4) != 0;
      in_data = 16'($urandom);
      #1;
      load = !eqv || q_ready;
      win = -1;
      if (load)
        for (int k = 1; k <= 4; k++)
          if (win < 0 && in_valid[(lg + k) % 4]) win = (lg + k) % 4;
      er = (win >= 0) ? 4'(1 << win) : 4'b0000;
      n_chk++;
      if (in_ready !== er) begin
        n_fail++;
        $display("FAIL rnd_rdy[%0d]: got %b want %b", n, in_ready, er);
      end
      if (win >= 0) begin
        eq = 4'(in_data >> (4 * win));
        es = win;
        eqv = 1;
        lg = win;
      end else if (load) begin
        eqv = 0;
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (q !== eq || q_valid !== eqv || q_sel !== 2'(es)) begin
        n_fail++;
        $display("FAIL rnd_q[%0d]: got %h/%b/%0d want %h/%b/%0d",
                 n, q, q_valid, q_sel, eq, eqv, es);
      end
    end
  endtask

`ifdef ARB_MUX_FORCE_EN
  task automatic test_force();
    test_reset();
    in_data = 16'h5371;
    q_ready = 1'b1;
    force_en = 1'b1;
    force_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 4'hF;
      #1;
      n_chk++;
      if (in_ready !== 4'b0100) begin
        n_fail++;
        $display("FAIL force_rdy[%0d]: got %b want 0100", i, in_ready);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (q_sel !== 2'd2 || q !== 4'd3) begin
        n_fail++;
        $display("FAIL force_q[%0d]: got s=%0d q=%0d want 2/3",
                 i, q_sel, q);
      end
    end
    @(negedge clk);
    force_en = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL force_resume: got %b want 0001", in_ready);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_backpressure();
    test_idle();
    test_async_reset();
`ifdef ARB_MUX_FORCE_EN
    test_force();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
